// File: rtl/xmtr_if.sv
// Host-side handshake and serial line of the framed-link transmitter.
// master = host producer, slave = xmtr.
interface xmtr_if;
  logic       load;
  logic [7:0] data_in;
  logic       clear;
  logic       ready;
  logic       busy;
  logic       sent;
  logic       overrun;
  logic       serial_out;

  modport master (output load, data_in, clear,
                  input  ready, busy, sent, overrun, serial_out);
  modport slave  (input  load, data_in, clear,
                  output ready, busy, sent, overrun, serial_out);
endinterface

// File: rtl/xmtr.sv
// Serial frame transmitter: 8-bit MATCH header then 8 data bits, MSB first.
// Define XMTR_HOLD_EN to add a one-entry holding register for back-to-back frames.
module xmtr #(
  parameter logic [7:0] MATCH      = 8'hA5,
  parameter logic       IDLE_LEVEL = 1'b0
) (
  input logic  clock,
  input logic  reset,
  xmtr_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] shift, shift_n;
  logic       ser, ser_n;
  logic       busy_r, busy_n;
  logic       sent_r, sent_n;
  logic       ovr, ovr_n;
  logic       ready, accept, last_edge;

`ifdef XMTR_HOLD_EN
  logic [7:0] hold, hold_n;
  logic       hold_valid, hold_valid_n;
  assign ready = !hold_valid;
`else
  assign ready = (state == IDLE);
`endif

  assign accept    = bus.load & ready;
  assign last_edge = (state == BODY) && (cnt == 3'd7);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    ser_n   = ser;
    busy_n  = busy_r;
    sent_n  = 1'b0;
    // a rejected load sets overrun even when clear is asserted
    ovr_n   = (ovr & ~bus.clear) | (bus.load & ~ready);
`ifdef XMTR_HOLD_EN
    hold_n       = hold;
    hold_valid_n = hold_valid;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          shift_n = bus.data_in;
          ser_n   = MATCH[7];
          cnt_n   = 3'd0;
          busy_n  = 1'b1;
          state_n = HEAD;
        end
      end
      HEAD: begin
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd7) begin
          ser_n   = shift[7];
          state_n = BODY;
        end else begin
          ser_n = MATCH[3'd6 - cnt];
        end
      end
      BODY: begin
        cnt_n = cnt + 3'd1;
        if (cnt != 3'd7) begin
          ser_n   = shift[6];
          shift_n = {shift[6:0], 1'b0};
        end else begin
          sent_n  = 1'b1;
          ser_n   = IDLE_LEVEL;
          busy_n  = 1'b0;
          state_n = IDLE;
`ifdef XMTR_HOLD_EN
          // held byte has priority; an empty hold lets a same-edge load bypass it
          if (hold_valid) begin
            shift_n      = hold;
            hold_valid_n = 1'b0;
            ser_n        = MATCH[7];
            busy_n       = 1'b1;
            state_n      = HEAD;
          end else if (accept) begin
            shift_n = bus.data_in;
            ser_n   = MATCH[7];
            busy_n  = 1'b1;
            state_n = HEAD;
          end
`endif
        end
      end
      default: begin
        state_n = IDLE;
        ser_n   = IDLE_LEVEL;
        busy_n  = 1'b0;
      end
    endcase
`ifdef XMTR_HOLD_EN
    if (accept && (state != IDLE) && !last_edge) begin
      hold_n       = bus.data_in;
      hold_valid_n = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      shift  <= 8'd0;
      ser    <= IDLE_LEVEL;
      busy_r <= 1'b0;
      sent_r <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shift  <= shift_n;
      ser    <= ser_n;
      busy_r <= busy_n;
      sent_r <= sent_n;
      ovr    <= ovr_n;
    end
  end

`ifdef XMTR_HOLD_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hold       <= 8'd0;
      hold_valid <= 1'b0;
    end else begin
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
    end
  end
`endif

  assign bus.ready      = ready;
  assign bus.busy       = busy_r;
  assign bus.sent       = sent_r;
  assign bus.overrun    = ovr;
  assign bus.serial_out = ser;
endmodule
